dcm_spi_master: RTL and testbench
=================================

Name: dcm_spi_master

Overview:
- Host-side SPI initiator that drives the dcmctrl register-file port (spi_ss/spi_clk/spi_mosi/spi_miso) from an on-chip controller.
- Turns a request (read/write, start address, byte count) plus a byte stream into one SPI frame.
- Frame format: command byte = {write flag, addr[6:0]}, followed by auto-incrementing data bytes.
- SPI mode 3: sclk idles high, mosi changes on the falling edge, miso is sampled on the rising edge, MSB first.

Parameters:
- CLK_DIV, 5: clk cycles per sclk half-period (minimum 2).
- SS_SETUP, 5: clk cycles from ss falling to the first sclk falling edge.
- SS_HOLD, 10: clk cycles with ss high after a frame, before the next frame may start.
- BYTE_GAP, 5: idle clk cycles between bytes, with sclk held high.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  transaction request valid
- req_ready  out  1  high only in IDLE
- req_write  in  1  1 = write, 0 = read
- req_addr  in  7  register start address
- req_len  in  8  number of data bytes, 0..255
- wr_valid  in  1  write byte valid
- wr_ready  out  1  write byte accepted this cycle
- wr_data  in  8  write byte
- rd_valid  out  1  one-cycle pulse, read byte available
- rd_data  out  8  read byte
- busy  out  1  frame in progress, including SS_HOLD
- done  out  1  one-cycle pulse at the end of SS_HOLD
- spi_ss  out  1  active-low slave select
- spi_clk  out  1  sclk
- spi_mosi  out  1  master out
- spi_miso  in  1  master in

Behaviour:
- Reset values: spi_ss=1, spi_clk=1, spi_mosi=0, req_ready=0 during reset and 1 after, wr_ready=0, rd_valid=0, rd_data=0, busy=0, done=0. Reset asserts asynchronously, immediately, even mid-bit; no partial byte is reported.
- States: IDLE, SETUP, LOAD, SHIFT, GAP, HOLD.
- IDLE -> SETUP on req_valid&&req_ready. Latch req_write, req_addr, req_len. spi_ss=0 in the same cycle.
- SETUP: count SS_SETUP cycles -> LOAD with the command byte {req_write, req_addr}.
- LOAD for the command byte: shift register loaded, go to SHIFT.
- LOAD for a write data byte: wr_ready=1; wait for wr_valid with sclk held high and no timeout; on the handshake, load wr_data -> SHIFT.
- LOAD for a read data byte: load 0x00 -> SHIFT.
- SHIFT, per bit: sclk=0 and mosi=current MSB for CLK_DIV cycles; then sclk=1 for CLK_DIV cycles.
- MISO sampling: miso is shifted in on the clk cycle in which sclk rises.
- 8 bits take 16*CLK_DIV cycles.
- After bit 0's high phase: on a read data byte (not the command byte), rd_data=received byte and rd_valid pulses 1 cycle. Write-frame miso bytes are discarded.
- SHIFT -> GAP if bytes remain, else HOLD.
- GAP: BYTE_GAP cycles -> LOAD.
- HOLD: spi_ss=1 on entry, mosi=0. After SS_HOLD cycles -> IDLE; done pulses 1 cycle; busy falls together with done.
- req_len=0: command byte only, then HOLD.
- Bytes per frame are req_len+1. The slave's address wraps at 127; the master does not check this.
- Internal counters: bit counter 3 bits, byte counter 8 bits, divider counter $clog2 of the largest timing parameter, plus 1 bit.
- A req_valid while busy is ignored (req_ready=0).

Optional Feature:
- Macro: DCM_SPI_MISO_SYNC_EN.
- Enabled: spi_miso passes through a 2-flop synchronizer, and sampling moves to 2 clk cycles after the sclk rise. CLK_DIV must be >=3; this is checked by a simulation-time $error.
- Disabled: spi_miso is sampled directly on the sclk-rise cycle, with no added flops.

Decomposition:
- Package dcm_spi_pkg holds:
  - the state enum;
  - CMD_WRITE_BIT=7 and ADDR_W=7;
  - register map constants: REG_CH_BASE=64, CH_STRIDE=4, OFS_SPEED=0, OFS_POS_HI=1, OFS_POS_MID=2, OFS_POS_LO=3.
- Sub-module dcm_spi_shifter: the sclk divider plus the 8-bit in/out shift register, with load, start and byte_done signals.

Test Plan:
- Zero-fill write, CLK_DIV=5 (bench runs the 10 ns clk): req write, addr 0, len 128, all bytes 0x00.
  - Slave model sees 0x80 then 128×0x00.
  - sclk period 100 ns.
  - ss low continuously, done once.
- Channel-0 setup: write addr 64, len 4, data 100,0,0,20.
  - MOSI bytes 0xC0,0x64,0x00,0x00,0x14.
  - mosi is stable on every sclk rising edge.
- Readback: read addr 64, len 4, slave returns 0x64,0x00,0x00,0x14.
  - Command byte 0x40.
  - MOSI data bytes 0x00.
  - Exactly 4 rd_valid pulses carrying those values.
- wr_valid withheld 500 ns before byte 2 -> sclk stays high and ss stays low; the frame then completes correctly.
- Reset asserted mid-SHIFT of byte 1 -> ss=1, sclk=1, mosi=0 within the same cycle. No rd_valid or done. A new request after reset works.
- req_len=0 read -> single command byte; zero rd_valid pulses; done after SS_HOLD.

Source files
------------

// File: rtl/dcm_spi_pkg.sv
// Shared types and constants for the dcmctrl SPI initiator.
// Holds the frame FSM states, command-byte layout and register map offsets.
package dcm_spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_LOAD,
      ST_SHIFT,
      ST_GAP,
      ST_HOLD
   } state_t;

   localparam int unsigned CMD_WRITE_BIT = 7;
   localparam int unsigned ADDR_W        = 7;

   localparam int unsigned REG_CH_BASE = 64;
   localparam int unsigned CH_STRIDE   = 4;
   localparam int unsigned OFS_SPEED   = 0;
   localparam int unsigned OFS_POS_HI  = 1;
   localparam int unsigned OFS_POS_MID = 2;
   localparam int unsigned OFS_POS_LO  = 3;

   function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                        input int unsigned c, input int unsigned d);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/dcm_spi_shifter.sv
// SPI mode-3 bit engine: sclk divider plus 8-bit MSB-first in/out shift register.
// DCM_SPI_MISO_SYNC_EN adds a 2-flop miso synchronizer and delays sampling by 2 clk.
module dcm_spi_shifter #(
   parameter int unsigned CLK_DIV = 5,
   parameter int unsigned DIV_W   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic       start,
   input  logic [7:0] load_data,
   input  logic       miso,
   output logic       sclk,
   output logic       mosi,
   output logic       byte_done,
   output logic [7:0] rx_data
);

   logic             active;
   logic [DIV_W-1:0] div;
   logic [2:0]       bit_cnt;
   logic [7:0]       sreg;
   logic             half_end;
   logic             rise;
   logic             sample_now;
   logic             sample_bit;

   assign half_end = active && (div == DIV_W'(CLK_DIV - 1));
   assign rise     = half_end && !sclk;
   assign rx_data  = sreg;

`ifdef DCM_SPI_MISO_SYNC_EN
   logic [1:0] miso_sync;
   logic [1:0] samp_pipe;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         miso_sync <= '0;
         samp_pipe <= '0;
      end else begin
         miso_sync <= {miso_sync[0], miso};
         samp_pipe <= {samp_pipe[0], rise};
      end
   end

   always_ff @(posedge clk) begin
      if (CLK_DIV < 3) $error("dcm_spi_shifter: CLK_DIV must be >= 3 with miso sync");
   end

   assign sample_now = samp_pipe[1];
   assign sample_bit = miso_sync[1];
`else
   assign sample_now = rise;
   assign sample_bit = miso;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active    <= 1'b0;
         div       <= '0;
         bit_cnt   <= '0;
         sreg      <= '0;
         sclk      <= 1'b1;
         mosi      <= 1'b0;
         byte_done <= 1'b0;
      end else begin
         byte_done <= 1'b0;
         if (load)
            sreg <= load_data;
         else if (sample_now)
            sreg <= {sreg[6:0], sample_bit};

         if (start) begin
            active  <= 1'b1;
            div     <= '0;
            bit_cnt <= 3'd7;
            sclk    <= 1'b0;
            mosi    <= load ? load_data[7] : sreg[7];
         end else if (active) begin
            if (half_end) begin
               div <= '0;
               if (!sclk) begin
                  sclk <= 1'b1;
               end else if (bit_cnt == 3'd0) begin
                  // sclk stays high after the last bit; mosi parks low between bytes
                  active    <= 1'b0;
                  byte_done <= 1'b1;
                  mosi      <= 1'b0;
               end else begin
                  bit_cnt <= bit_cnt - 1'b1;
                  sclk    <= 1'b0;
                  mosi    <= sreg[7];
               end
            end else begin
               div <= div + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/dcm_spi_master.sv
// Host-side SPI initiator for the dcmctrl register port: one request becomes one frame.
// Optional DCM_SPI_MISO_SYNC_EN (in dcm_spi_shifter) synchronizes spi_miso.
module dcm_spi_master
   import dcm_spi_pkg::*;
#(
   parameter int unsigned CLK_DIV  = 5,
   parameter int unsigned SS_SETUP = 5,
   parameter int unsigned SS_HOLD  = 10,
   parameter int unsigned BYTE_GAP = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [7:0]        req_len,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [7:0]        wr_data,
   output logic              rd_valid,
   output logic [7:0]        rd_data,
   output logic              busy,
   output logic              done,
   output logic              spi_ss,
   output logic              spi_clk,
   output logic              spi_mosi,
   input  logic              spi_miso
);

   localparam int unsigned CNT_W = $clog2(max4(CLK_DIV, SS_SETUP, SS_HOLD, BYTE_GAP)) + 1;

   state_t             state, state_n;
   logic [CNT_W-1:0]   cnt;
   logic               lat_write;
   logic [ADDR_W-1:0]  lat_addr;
   logic [7:0]         len_left;
   logic               is_cmd;
   logic               ss_q;
   logic               last_byte;
   logic               sh_load, sh_start, sh_done;
   logic [7:0]         sh_load_data, sh_rx;

   assign req_ready = (state == ST_IDLE) && !reset;
   assign busy      = (state != ST_IDLE);
   assign spi_ss    = ss_q;
   assign last_byte = is_cmd ? (len_left == 8'd0) : (len_left == 8'd1);

   always_comb begin
      state_n      = state;
      sh_load      = 1'b0;
      sh_start     = 1'b0;
      sh_load_data = '0;
      wr_ready     = 1'b0;
      unique case (state)
         ST_IDLE:  if (req_valid && req_ready) state_n = ST_SETUP;
         // LOAD adds one cycle before sclk falls, so SETUP runs one short
         ST_SETUP: if (cnt == CNT_W'(SS_SETUP - 2)) state_n = ST_LOAD;
         ST_LOAD: begin
            if (is_cmd) begin
               sh_load_data[CMD_WRITE_BIT] = lat_write;
               sh_load_data[ADDR_W-1:0]    = lat_addr;
               sh_load  = 1'b1;
               sh_start = 1'b1;
               state_n  = ST_SHIFT;
            end else if (lat_write) begin
               wr_ready = 1'b1;
               if (wr_valid) begin
                  sh_load_data = wr_data;
                  sh_load      = 1'b1;
                  sh_start     = 1'b1;
                  state_n      = ST_SHIFT;
               end
            end else begin
               sh_load  = 1'b1;
               sh_start = 1'b1;
               state_n  = ST_SHIFT;
            end
         end
         ST_SHIFT: if (sh_done) state_n = last_byte ? ST_HOLD : ST_GAP;
         ST_GAP:   if (cnt == CNT_W'(BYTE_GAP - 1)) state_n = ST_LOAD;
         ST_HOLD:  if (cnt == CNT_W'(SS_HOLD - 1)) state_n = ST_IDLE;
         default:  state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         lat_write <= 1'b0;
         lat_addr  <= '0;
         len_left  <= '0;
         is_cmd    <= 1'b0;
         ss_q      <= 1'b1;
         done      <= 1'b0;
         rd_valid  <= 1'b0;
         rd_data   <= '0;
      end else begin
         state    <= state_n;
         cnt      <= (state_n != state) ? '0 : cnt + 1'b1;
         ss_q     <= (state_n == ST_IDLE) || (state_n == ST_HOLD);
         done     <= (state == ST_HOLD) && (state_n == ST_IDLE);
         rd_valid <= 1'b0;
         if (state == ST_IDLE && req_valid) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            len_left  <= req_len;
            is_cmd    <= 1'b1;
         end
         if (state == ST_SHIFT && sh_done) begin
            if (is_cmd) begin
               is_cmd <= 1'b0;
            end else begin
               len_left <= len_left - 1'b1;
               if (!lat_write) begin
                  rd_valid <= 1'b1;
                  rd_data  <= sh_rx;
               end
            end
         end
      end
   end

   dcm_spi_shifter #(
      .CLK_DIV (CLK_DIV),
      .DIV_W   (CNT_W)
   ) u_shifter (
      .clk       (clk),
      .reset     (reset),
      .load      (sh_load),
      .start     (sh_start),
      .load_data (sh_load_data),
      .miso      (spi_miso),
      .sclk      (spi_clk),
      .mosi      (spi_mosi),
      .byte_done (sh_done),
      .rx_data   (sh_rx)
   );

endmodule

// File: tb/tb_dcm_spi_master.sv
// Self-checking bench for dcm_spi_master: SPI slave monitor plus frame-level reference model.
module tb_dcm_spi_master;

   localparam int unsigned CLK_DIV  = 5;
   localparam int unsigned SS_SETUP = 5;
   localparam int unsigned SS_HOLD  = 10;
   localparam int unsigned BYTE_GAP = 5;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_write = 1'b0;
   logic [6:0] req_addr = '0;
   logic [7:0] req_len = '0;
   logic       wr_valid = 1'b0;
   logic [7:0] wr_data = '0;
   logic       spi_miso = 1'b1;
   logic       req_ready, wr_ready, rd_valid, busy, done, spi_ss, spi_clk, spi_mosi;
   logic [7:0] rd_data;

   always #5 clk = ~clk;

   dcm_spi_master #(
      .CLK_DIV  (CLK_DIV),
      .SS_SETUP (SS_SETUP),
      .SS_HOLD  (SS_HOLD),
      .BYTE_GAP (BYTE_GAP)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_len   (req_len),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_data   (wr_data),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .busy      (busy),
      .done      (done),
      .spi_ss    (spi_ss),
      .spi_clk   (spi_clk),
      .spi_mosi  (spi_mosi),
      .spi_miso  (spi_miso)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Slave/monitor state, all sampled on the falling clk edge
   int         cyc = 0;
   logic       prev_ss = 1'b1, prev_sclk = 1'b1, prev_mosi = 1'b0;
   int         bit_i = 0, bidx = 0;
   logic [7:0] rxb = '0, txb = '0;
   logic [7:0] mosi_q[$];
   logic [7:0] rd_q[$];
   int         done_cnt = 0, ss_fall_cnt = 0, ss_rise_cnt = 0, glitch = 0;
   int         ss_fall_cyc = 0, first_fall_cyc = 0, ss_rise_cyc = 0, done_cyc = 0;
   int         last_rise = 0, per_min = 1000, per_max = 0;
   bit         first_fall_seen = 1'b0;
   logic       busy_at_done = 1'b0;
   logic [7:0] wr_buf[256];
   logic [7:0] sl_buf[256];

   always @(negedge clk) begin
      cyc++;
      if (!reset) begin
         if (prev_ss && !spi_ss) begin
            ss_fall_cnt++;
            ss_fall_cyc = cyc;
            bit_i = 0;
            bidx = 0;
            first_fall_seen = 1'b0;
         end
         if (!prev_ss && spi_ss) begin
            ss_rise_cnt++;
            ss_rise_cyc = cyc;
         end
         if (!spi_ss) begin
            if (prev_sclk && !spi_clk) begin
               if (!first_fall_seen) begin
                  first_fall_seen = 1'b1;
                  first_fall_cyc = cyc;
               end
               txb = (bidx == 0) ? 8'hA5 : sl_buf[(bidx - 1) % 256];
               spi_miso = txb[7 - bit_i];
            end
            if (!prev_sclk && spi_clk) begin
               if (bit_i != 0) begin
                  if (cyc - last_rise < per_min) per_min = cyc - last_rise;
                  if (cyc - last_rise > per_max) per_max = cyc - last_rise;
               end
               last_rise = cyc;
               rxb = {rxb[6:0], spi_mosi};
               bit_i++;
               if (bit_i == 8) begin
                  mosi_q.push_back(rxb);
                  bit_i = 0;
                  bidx++;
               end
            end
            if (!prev_sclk && (spi_mosi !== prev_mosi)) glitch++;
         end
         if (rd_valid) rd_q.push_back(rd_data);
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            busy_at_done = busy;
         end
      end
      prev_ss = spi_ss;
      prev_sclk = spi_clk;
      prev_mosi = spi_mosi;
   end

   task automatic clear_mon();
      mosi_q.delete();
      rd_q.delete();
      done_cnt = 0;
      ss_fall_cnt = 0;
      ss_rise_cnt = 0;
      glitch = 0;
      per_min = 1000;
      per_max = 0;
   endtask

   task automatic issue_req(input logic w, input logic [6:0] addr, input int len);
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("req_ready_idle", req_ready, 1);
      req_valid = 1'b1;
      req_write = w;
      req_addr = addr;
      req_len = 8'(len);
      @(posedge clk);
      #1 req_valid = 1'b0;
      check("busy_after_req", busy, 1);
      check("req_ready_busy", req_ready, 0);
   endtask

   task automatic run_frame(input string name, input logic w, input logic [6:0] addr,
                            input int len, input int stall_idx);
      int n;
      logic ok;
      logic [7:0] exp_mosi[$];
      logic [7:0] exp_rd[$];
      clear_mon();
      issue_req(w, addr, len);
      if (w) begin
         for (int i = 0; i < len; i++) begin
            n = 0;
            @(negedge clk);
            while (!wr_ready && n < 2000) begin
               @(negedge clk);
               n++;
            end
            check({name, "_wr_ready"}, wr_ready, 1);
            if (!wr_ready) break;
            if (i == stall_idx) begin
               ok = 1'b1;
               repeat (50) begin
                  @(negedge clk);
                  if (!spi_clk || spi_ss || !wr_ready) ok = 1'b0;
               end
               check({name, "_stall_hold"}, ok, 1);
            end
            wr_valid = 1'b1;
            wr_data = wr_buf[i];
            @(posedge clk);
            #1 wr_valid = 1'b0;
         end
      end
      n = 0;
      while (done_cnt == 0 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check({name, "_done_seen"}, (done_cnt > 0), 1);
      repeat (3) @(negedge clk);

      // Reference: command byte, then write data or 0x00 filler; reads return slave bytes
      exp_mosi.push_back({w, addr});
      for (int i = 0; i < len; i++) begin
         exp_mosi.push_back(w ? wr_buf[i] : 8'h00);
         if (!w) exp_rd.push_back(sl_buf[i]);
      end

      check({name, "_mosi_count"}, mosi_q.size(), exp_mosi.size());
      for (int i = 0; i < exp_mosi.size(); i++)
         check($sformatf("%s_mosi[%0d]", name, i),
               (i < mosi_q.size()) ? 32'(mosi_q[i]) : 32'hFFFF_FFFF, 32'(exp_mosi[i]));
      check({name, "_rd_count"}, rd_q.size(), exp_rd.size());
      for (int i = 0; i < exp_rd.size(); i++)
         check($sformatf("%s_rd[%0d]", name, i),
               (i < rd_q.size()) ? 32'(rd_q[i]) : 32'hFFFF_FFFF, 32'(exp_rd[i]));
      check({name, "_done_once"}, done_cnt, 1);
      check({name, "_ss_fall_once"}, ss_fall_cnt, 1);
      check({name, "_ss_rise_once"}, ss_rise_cnt, 1);
      check({name, "_mosi_stable"}, glitch, 0);
      check({name, "_sclk_per_min"}, per_min, 2 * CLK_DIV);
      check({name, "_sclk_per_max"}, per_max, 2 * CLK_DIV);
      check({name, "_ss_setup"}, first_fall_cyc - ss_fall_cyc, SS_SETUP);
      check({name, "_ss_hold"}, done_cyc - ss_rise_cyc, SS_HOLD);
      check({name, "_busy_at_done"}, busy_at_done, 0);
      check({name, "_idle_after"}, {busy, spi_ss, spi_clk, spi_mosi}, 4'b0110);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [6:0] a;
      int len;

      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_ss", spi_ss, 1);
      check("rst_sclk", spi_clk, 1);
      check("rst_mosi", spi_mosi, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_wr_ready", wr_ready, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      reset = 1'b0;
      @(negedge clk);
      check("req_ready_after_rst", req_ready, 1);

      for (int i = 0; i < 256; i++) begin
         wr_buf[i] = 8'h00;
         sl_buf[i] = 8'($urandom);
      end
      run_frame("zero_fill", 1'b1, 7'd0, 128, -1);

      wr_buf[0] = 8'd100; wr_buf[1] = 8'd0; wr_buf[2] = 8'd0; wr_buf[3] = 8'd20;
      run_frame("ch0_setup", 1'b1, 7'd64, 4, -1);

      sl_buf[0] = 8'h64; sl_buf[1] = 8'h00; sl_buf[2] = 8'h00; sl_buf[3] = 8'h14;
      run_frame("readback", 1'b0, 7'd64, 4, -1);

      for (int i = 0; i < 8; i++) wr_buf[i] = 8'($urandom);
      a = 7'($urandom_range(0, 127));
      run_frame("wr_stall", 1'b1, a, 5, 2);

      // Reset in the middle of the first data byte of a read
      clear_mon();
      for (int i = 0; i < 4; i++) sl_buf[i] = 8'($urandom);
      issue_req(1'b0, 7'($urandom_range(0, 127)), 2);
      n = 0;
      while (!(mosi_q.size() == 1 && !spi_clk) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("rst_mid_reach_shift", (mosi_q.size() == 1 && !spi_clk), 1);
      repeat (23) @(negedge clk);
      check("rst_mid_ss_low", spi_ss, 0);
      #2 reset = 1'b1;
      #1;
      check("rst_mid_ss", spi_ss, 1);
      check("rst_mid_sclk", spi_clk, 1);
      check("rst_mid_mosi", spi_mosi, 0);
      check("rst_mid_busy", busy, 0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (300) @(negedge clk);
      check("rst_mid_no_rd", rd_q.size(), 0);
      check("rst_mid_no_done", done_cnt, 0);

      len = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) sl_buf[i] = 8'($urandom);
      run_frame("after_rst_rd", 1'b0, 7'($urandom_range(0, 127)), len, -1);

      run_frame("len0_read", 1'b0, 7'($urandom_range(0, 127)), 0, -1);

      len = $urandom_range(1, 6);
      for (int i = 0; i < 8; i++) wr_buf[i] = 8'($urandom);
      run_frame("rand_wr", 1'b1, 7'($urandom_range(0, 127)), len, -1);
      len = $urandom_range(1, 6);
      for (int i = 0; i < 8; i++) sl_buf[i] = 8'($urandom);
      run_frame("rand_rd", 1'b0, 7'($urandom_range(0, 127)), len, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
